// File: rtl/pk_extract_pkg.sv
// Shared definitions for the public-key extractor: default geometry,
// derived word counts, FSM encoding and a width helper.
package pk_extract_pkg;

  // Default geometry, matching the upstream systemizer.
  localparam int DEF_N = 20;
  localparam int DEF_L = 200;
  localparam int DEF_K = 400;

  // Derived counts for the default geometry.
  localparam int W      = DEF_K / DEF_N;
  localparam int S      = DEF_L / DEF_N;
  localparam int TW     = W - S;
  localparam int TOTAL  = DEF_L * TW;
  localparam int ADDR_W = $clog2(DEF_L * DEF_K / DEF_N);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  // Counter width that stays at least one bit for tiny ranges.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pk_word_fifo.sv
// Two-entry FIFO whose head entry drives the output directly from a
// register, so the presented word never glitches while it waits.
module pk_word_fifo
  import pk_extract_pkg::*;
#(
  parameter int WIDTH = DEF_N + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [1:0]       count
);

  logic [WIDTH-1:0] head;
  logic [WIDTH-1:0] tail;

  // Head/tail shift storage; the head is always the oldest word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            head  <= din;
            count <= 2'd1;
          end else if (count == 2'd1) begin
            tail  <= din;
            count <= 2'd2;
          end
        end
        2'b01: begin
          if (count != 2'd0) begin
            head  <= tail;
            count <= count - 2'd1;
          end
        end
        2'b11: begin
          if (count == 2'd1) begin
            head <= din;
          end else if (count == 2'd2) begin
            head <= tail;
            tail <= din;
          end else begin
            head  <= din;
            count <= 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout  = head;
  assign full  = (count == 2'd2);
  assign empty = (count == 2'd0);

endmodule

// File: rtl/pk_extract.sv
// Public-key extractor: walks the systemized matrix row by row, skips the
// identity block and streams the remaining T words to the key consumer.
module pk_extract
  import pk_extract_pkg::*;
#(
  parameter int N = DEF_N,
  parameter int L = DEF_L,
  parameter int K = DEF_K
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       sys_fail,
  output logic                       rd_en,
  output logic [$clog2(L*K/N)-1:0]   rd_addr,
  input  logic [N-1:0]               rd_data,
  output logic [N-1:0]               out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic                       out_last,
  output logic                       busy,
  output logic                       done,
  output logic                       fail
);

  localparam int ROW_WORDS = K / N;
  localparam int ID_WORDS  = L / N;
  localparam int AW        = $clog2(L * K / N);
  localparam int BLK_W     = cnt_width(ROW_WORDS);
  localparam int ROW_W     = cnt_width(L);

  state_t           state;
  state_t           state_nx;
  logic [BLK_W-1:0] blk;
  logic [ROW_W-1:0] row;
  logic             inflight;
  logic             inflight_last;
  logic             load;
  logic             finish;
  logic             last_issue;
  logic             credit_ok;
  logic [2:0]       outstanding;
  logic             push;
  logic             pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [1:0]       fifo_count;
  logic [N:0]       fifo_dout;

  assign pop         = out_valid && out_ready;
  assign push        = inflight && (!fifo_full || pop);
  assign outstanding = {1'b0, fifo_count} + {2'b00, inflight};
  // Never let queued plus in-flight words exceed the two FIFO slots.
  assign credit_ok   = (outstanding < 3'd2) || (pop && (outstanding < 3'd3));
  assign last_issue  = (row == ROW_W'(L - 1)) && (blk == BLK_W'(ROW_WORDS - 1));

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nx;
  end

  // Next-state and read-issue decode.
  always_comb begin
    state_nx = state;
    rd_en    = 1'b0;
    load     = 1'b0;
    finish   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start && !sys_fail) begin
          load     = 1'b1;
          state_nx = ST_READ;
        end
      end
      ST_READ: begin
        if (credit_ok) begin
          rd_en = 1'b1;
          if (last_issue) state_nx = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Leave as the final word is accepted so done lands one cycle later.
        if (!inflight && (fifo_empty || ((fifo_count == 2'd1) && pop))) begin
          finish   = 1'b1;
          state_nx = ST_FIN;
        end
      end
      ST_FIN:  state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // Status flags: completion pulse, sticky upstream failure, busy window.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      done <= 1'b0;
      fail <= 1'b0;
      busy <= 1'b0;
    end else begin
      done <= finish || ((state == ST_IDLE) && start && sys_fail);
      if ((state == ST_IDLE) && start) fail <= sys_fail;
      if (load)                  busy <= 1'b1;
      else if (state == ST_FIN)  busy <= 1'b0;
    end
  end

  // Row/block walk with a running address; a row wrap skips the identity words.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row     <= '0;
      blk     <= '0;
      rd_addr <= '0;
    end else if (load) begin
      row     <= '0;
      blk     <= BLK_W'(ID_WORDS);
      rd_addr <= AW'(ID_WORDS);
    end else if (rd_en && !last_issue) begin
      if (blk == BLK_W'(ROW_WORDS - 1)) begin
        blk     <= BLK_W'(ID_WORDS);
        row     <= row + 1'b1;
        rd_addr <= rd_addr + AW'(ID_WORDS + 1);
      end else begin
        blk     <= blk + 1'b1;
        rd_addr <= rd_addr + 1'b1;
      end
    end
  end

  // Track the read whose data arrives next cycle, tagging the final one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight      <= 1'b0;
      inflight_last <= 1'b0;
    end else begin
      inflight      <= rd_en;
      inflight_last <= rd_en && last_issue;
    end
  end

  pk_word_fifo #(.WIDTH(N + 1)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   ({inflight_last, rd_data}),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  assign out_data  = fifo_dout[N-1:0];
  assign out_valid = !fifo_empty;
  assign out_last  = fifo_dout[N] && !fifo_empty;

endmodule
